// File: rtl/dds_pkg.sv
// Shared widths and FSM encoding for the DDS phase-accumulator address generator.
package dds_pkg;

    localparam int unsigned DDS_ACC_W  = 32;
    localparam int unsigned DDS_ADDR_W = 11;
    localparam int unsigned DDS_MODE_W = 3;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] PEND = 2'd2;

    typedef enum logic [1:0] {
        StIdle = IDLE,
        StRun  = RUN,
        StPend = PEND
    } dds_state_e;

endpackage

// File: rtl/dds_acc_core.sv
// Phase accumulator: modulo-2^ACC_W adder, carry detect, registered wrap pulse and clear.
module dds_acc_core #(
    parameter int unsigned ACC_W  = 32,
    parameter int unsigned ADDR_W = 11
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              adv_i,
    input  logic              clr_i,
    input  logic [ACC_W-1:0]  ftw_i,
    output logic [ADDR_W-1:0] addr_o,
    output logic              carry_o,
    output logic              wrap_o
);

    logic [ACC_W-1:0] acc_q;
    logic [ACC_W:0]   sum;
    logic             wrap_q;

    assign sum     = {1'b0, acc_q} + {1'b0, ftw_i};
    assign carry_o = sum[ACC_W];
    assign addr_o  = acc_q[ACC_W-1 -: ADDR_W];
    assign wrap_o  = wrap_q;

    // Clear wins over both accumulation and a coincident carry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q  <= '0;
            wrap_q <= 1'b0;
        end else if (clr_i) begin
            acc_q  <= '0;
            wrap_q <= 1'b0;
        end else if (adv_i) begin
            acc_q  <= sum[ACC_W-1:0];
            wrap_q <= sum[ACC_W];
        end else begin
            wrap_q <= 1'b0;
        end
    end

endmodule

// File: rtl/dds_phase_gen.sv
// DDS address generator: config handshake, shadow registers and wrap-aligned config apply.
module dds_phase_gen
    import dds_pkg::*;
#(
    parameter int unsigned ACC_W  = DDS_ACC_W,
    parameter int unsigned ADDR_W = DDS_ADDR_W,
    parameter int unsigned MODE_W = DDS_MODE_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              En_i,
    input  logic              Sync_clr_i,
    input  logic [ACC_W-1:0]  Ftw_i,
    input  logic [MODE_W-1:0] Mode_i,
    input  logic              Cfg_valid_i,
    output logic              Cfg_ready_o,
    output logic [ADDR_W-1:0] Address_o,
    output logic [MODE_W-1:0] Mode_o,
    output logic              Wrap_o,
    output logic              Valid_o
);

    dds_state_e        state_q, state_d;
    logic [ACC_W-1:0]  ftw_q, ftw_d;
    logic [MODE_W-1:0] mode_q, mode_d;
    logic [ACC_W-1:0]  sh_ftw_q, sh_ftw_d;
    logic [MODE_W-1:0] sh_mode_q, sh_mode_d;
    logic              valid_q, valid_d;
    logic              xfer;
    logic              adv;
    logic              carry;

    assign Cfg_ready_o = (state_q != StPend);
    assign xfer        = Cfg_valid_i & Cfg_ready_o;
    assign Mode_o      = mode_q;
    assign Valid_o     = valid_q;

    dds_acc_core #(
        .ACC_W  (ACC_W),
        .ADDR_W (ADDR_W)
    ) u_acc_core (
        .clk     (clk),
        .rst_n   (rst_n),
        .adv_i   (adv),
        .clr_i   (Sync_clr_i),
        .ftw_i   (ftw_q),
        .addr_o  (Address_o),
        .carry_o (carry),
        .wrap_o  (Wrap_o)
    );

    always_comb begin
        state_d   = state_q;
        ftw_d     = ftw_q;
        mode_d    = mode_q;
        sh_ftw_d  = sh_ftw_q;
        sh_mode_d = sh_mode_q;
        adv       = 1'b0;
        valid_d   = (state_q != StIdle) && En_i;

        unique case (state_q)
            StIdle: begin
                if (xfer) begin
                    ftw_d  = Ftw_i;
                    mode_d = Mode_i;
                end
                if (En_i) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                adv = En_i;
                if (!En_i) begin
                    state_d = StIdle;
                end
                if (xfer) begin
                    sh_ftw_d  = Ftw_i;
                    sh_mode_d = Mode_i;
                    // Leaving RUN or clearing this edge: nothing left to wait for, apply now.
                    if (!En_i || Sync_clr_i) begin
                        ftw_d  = Ftw_i;
                        mode_d = Mode_i;
                    end else begin
                        state_d = StPend;
                    end
                end
            end
            StPend: begin
                adv = En_i;
                // A zero FTW never carries, so it must not block the pending config.
                if (Sync_clr_i || !En_i || carry || (ftw_q == '0)) begin
                    ftw_d   = sh_ftw_q;
                    mode_d  = sh_mode_q;
                    state_d = En_i ? StRun : StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            ftw_q     <= '0;
            mode_q    <= '0;
            sh_ftw_q  <= '0;
            sh_mode_q <= '0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            ftw_q     <= ftw_d;
            mode_q    <= mode_d;
            sh_ftw_q  <= sh_ftw_d;
            sh_mode_q <= sh_mode_d;
            valid_q   <= valid_d;
        end
    end

endmodule

// File: tb/tb_dds_phase_gen.sv
// Self-checking bench for dds_phase_gen: directed scenarios plus random traffic vs. a behavioural model.
module tb_dds_phase_gen;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        En_i = 1'b0;
    logic        Sync_clr_i = 1'b0;
    logic [31:0] Ftw_i = '0;
    logic [2:0]  Mode_i = '0;
    logic        Cfg_valid_i = 1'b0;
    logic        Cfg_ready_o;
    logic [10:0] Address_o;
    logic [2:0]  Mode_o;
    logic        Wrap_o;
    logic        Valid_o;

    dds_phase_gen #(
        .ACC_W  (32),
        .ADDR_W (11),
        .MODE_W (3)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .En_i        (En_i),
        .Sync_clr_i  (Sync_clr_i),
        .Ftw_i       (Ftw_i),
        .Mode_i      (Mode_i),
        .Cfg_valid_i (Cfg_valid_i),
        .Cfg_ready_o (Cfg_ready_o),
        .Address_o   (Address_o),
        .Mode_o      (Mode_o),
        .Wrap_o      (Wrap_o),
        .Valid_o     (Valid_o)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_bad = 0;

    // Behavioural model: running flag, one-deep pending config, 32-bit phase.
    bit              m_run, m_pend, m_wrap, m_valid;
    longint unsigned m_acc, m_ftw, m_sh_ftw;
    int unsigned     m_mode, m_sh_mode;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_run = 0; m_pend = 0; m_wrap = 0; m_valid = 0;
        m_acc = 0; m_ftw = 0; m_sh_ftw = 0; m_mode = 0; m_sh_mode = 0;
    endtask

    task automatic model_edge();
        longint unsigned sum;
        bit carry, xfer;
        sum   = m_acc + m_ftw;
        carry = (sum >= 64'h1_0000_0000);
        xfer  = Cfg_valid_i && !m_pend;
        if (!m_run) begin
            if (xfer) begin
                m_ftw  = Ftw_i;
                m_mode = Mode_i;
            end
            if (Sync_clr_i) m_acc = 0;
            m_wrap  = 0;
            m_valid = 0;
        end else begin
            m_valid = En_i;
            m_wrap  = !Sync_clr_i && En_i && carry;
            if (Sync_clr_i) m_acc = 0;
            else if (En_i) m_acc = sum % 64'h1_0000_0000;
            if (m_pend) begin
                if (Sync_clr_i || !En_i || carry || m_ftw == 0) begin
                    m_ftw  = m_sh_ftw;
                    m_mode = m_sh_mode;
                    m_pend = 0;
                end
            end else if (xfer) begin
                if (Sync_clr_i || !En_i) begin
                    m_ftw  = Ftw_i;
                    m_mode = Mode_i;
                end else begin
                    m_sh_ftw  = Ftw_i;
                    m_sh_mode = Mode_i;
                    m_pend    = 1;
                end
            end
        end
        m_run = En_i;
    endtask

    task automatic compare_all(input string tag);
        check({tag, ".addr"},  64'(Address_o),   64'(m_acc / 64'h20_0000));
        check({tag, ".mode"},  64'(Mode_o),      64'(m_mode));
        check({tag, ".wrap"},  64'(Wrap_o),      64'(m_wrap));
        check({tag, ".valid"}, 64'(Valid_o),     64'(m_valid));
        check({tag, ".ready"}, 64'(Cfg_ready_o), 64'(!m_pend));
    endtask

    task automatic cyc(input string tag);
        model_edge();
        @(posedge clk);
        #1;
        compare_all(tag);
    endtask

    task automatic offer(input logic [31:0] f, input logic [2:0] m);
        bit rdy, done;
        done        = 0;
        Cfg_valid_i = 1'b1;
        Ftw_i       = f;
        Mode_i      = m;
        for (int i = 0; i < 200 && !done; i++) begin
            rdy = Cfg_ready_o;
            cyc("offer");
            done = rdy;
        end
        Cfg_valid_i = 1'b0;
        if (!done) check("offer_timeout", 0, 1);
    endtask

    initial begin
        int          wraps;
        bit          found;
        bit          rdy;
        logic [10:0] frozen;

        model_reset();
        #12;
        rst_n = 1'b1;
        compare_all("reset");

        // Linear sweep: +1 address per cycle, single wrap 0x7FF -> 0x000.
        offer(32'h0020_0000, 3'd0);
        En_i  = 1'b1;
        wraps = 0;
        for (int i = 0; i < 2060; i++) begin
            cyc("sweep");
            if (Wrap_o === 1'b1) begin
                wraps++;
                check("sweep_wrap_addr", 64'(Address_o), 64'h0);
            end
        end
        check("sweep_wraps", 64'(wraps), 64'd1);

        // Phase-continuous change requested at address 100.
        found = 0;
        for (int i = 0; i < 3000 && !found; i++) begin
            if (Address_o == 11'd100) found = 1;
            else cyc("to100");
        end
        check("reach_100", 64'(found), 64'd1);
        offer(32'h0040_0000, 3'd4);
        check("pend_ready", 64'(Cfg_ready_o), 64'd0);
        check("pend_mode_held", 64'(Mode_o), 64'd0);
        for (int i = 0; i < 2100; i++) cyc("phase_cont");
        check("after_wrap_mode", 64'(Mode_o), 64'd4);

        // Half-scale FTW: alternating 0x000 / 0x400.
        En_i = 1'b0;
        cyc("stop");
        Sync_clr_i = 1'b1;
        cyc("clr_idle");
        Sync_clr_i = 1'b0;
        offer(32'h8000_0000, 3'd1);
        En_i = 1'b1;
        for (int i = 0; i < 20; i++) cyc("half");

        // Clear coincident with a carry applies the pending config.
        offer(32'h1000_0000, 3'd2);
        found = 0;
        for (int i = 0; i < 10 && !found; i++) begin
            if (m_acc == 64'h8000_0000) found = 1;
            else cyc("to_carry");
        end
        check("carry_setup", 64'(found), 64'd1);
        Sync_clr_i = 1'b1;
        cyc("clr_carry");
        Sync_clr_i = 1'b0;
        check("clr_addr", 64'(Address_o), 64'h0);
        check("clr_wrap", 64'(Wrap_o), 64'd0);
        check("clr_mode", 64'(Mode_o), 64'd2);
        check("clr_ready", 64'(Cfg_ready_o), 64'd1);

        // Zero FTW while pending: apply on the very next edge.
        En_i = 1'b0;
        cyc("stop2");
        offer(32'h0, 3'd0);
        En_i = 1'b1;
        cyc("zero_run");
        cyc("zero_run");
        offer(32'h0012_3456, 3'd5);
        cyc("zero_apply");
        check("zero_ftw_mode", 64'(Mode_o), 64'd5);
        check("zero_ftw_ready", 64'(Cfg_ready_o), 64'd1);

        // Offer held while not ready: only one transfer.
        Cfg_valid_i = 1'b1;
        Ftw_i       = 32'h0100_0000;
        Mode_i      = 3'd3;
        cyc("hold_xfer");
        for (int i = 0; i < 5; i++) begin
            cyc("hold");
            check("hold_ready", 64'(Cfg_ready_o), 64'd0);
        end
        Cfg_valid_i = 1'b0;
        found = 0;
        for (int i = 0; i < 5000 && !found; i++) begin
            if (Cfg_ready_o === 1'b1) found = 1;
            else cyc("hold_wait");
        end
        check("hold_applied", 64'(found), 64'd1);
        check("hold_mode", 64'(Mode_o), 64'd3);

        // En dropped while pending: config applied, phase frozen.
        offer(32'h0200_0000, 3'd6);
        En_i = 1'b0;
        cyc("en_drop");
        check("en_drop_mode", 64'(Mode_o), 64'd6);
        frozen = Address_o;
        for (int i = 0; i < 3; i++) cyc("frozen");
        check("frozen_addr", 64'(Address_o), 64'(frozen));

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            En_i       = ($urandom_range(0, 9) != 0);
            Sync_clr_i = ($urandom_range(0, 49) == 0);
            if (!Cfg_valid_i && $urandom_range(0, 7) == 0) begin
                Cfg_valid_i = 1'b1;
                Ftw_i       = ($urandom_range(0, 9) == 0) ? 32'h0 : ($urandom >> $urandom_range(0, 8));
                Mode_i      = 3'($urandom);
            end
            rdy = Cfg_ready_o;
            cyc("rand");
            if (Cfg_valid_i && rdy) Cfg_valid_i = 1'b0;
        end

        // Asynchronous reset mid-run, no clock edge needed.
        Cfg_valid_i = 1'b0;
        Sync_clr_i  = 1'b0;
        En_i        = 1'b1;
        offer(32'h0300_0000, 3'd7);
        cyc("pre_rst");
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        compare_all("async_rst");
        #3;
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) cyc("post_rst");

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/dds_phase_gen.md
Name: dds_phase_gen

Overview:
Phase-accumulator address generator that produces the Address_i/Mode_i stream consumed by the fillter_mode4 waveform-address filter.
- Each enabled cycle it adds a frequency tuning word (FTW) to a wide accumulator and drives the top ADDR_W bits as the table address.
- New FTW/mode settings arrive through a valid/ready handshake.
- While running, new settings take effect only at the accumulator wrap, so waveform and mode changes are phase-continuous.

Parameters:
ACC_W, 32, accumulator/FTW width in bits
ADDR_W, 11, output address width; Address_o = acc[ACC_W-1 -: ADDR_W]
MODE_W, 3, mode field width

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
En_i  input  1  run enable
Sync_clr_i  input  1  synchronous accumulator clear
Ftw_i  input  ACC_W  tuning word offered with Cfg_valid_i
Mode_i  input  MODE_W  mode offered with Cfg_valid_i
Cfg_valid_i  input  1  config offer
Cfg_ready_o  output  1  config accept
Address_o  output  ADDR_W  table address (to filter Address_i)
Mode_o  output  MODE_W  active mode (to filter Mode_i)
Wrap_o  output  1  one-cycle pulse after accumulator carry-out
Valid_o  output  1  Address_o is advancing

Behaviour:
- Reset (rst_n=0, asynchronous):
  - acc=0, ftw_act=0, shadow regs=0, Mode_o=0, Address_o=0.
  - Wrap_o=0, Valid_o=0, Cfg_ready_o=1, state=IDLE.
- States:
  - IDLE: not accumulating.
  - RUN: accumulating, no config pending.
  - PEND: accumulating, config held in shadow regs.
- Handshake:
  - A transfer occurs on a rising edge with Cfg_valid_i=1 and Cfg_ready_o=1.
  - Cfg_ready_o=1 in IDLE and RUN, 0 in PEND.
  - If Cfg_valid_i is high while Cfg_ready_o is low, there is no transfer; the source holds its offer.
- IDLE transfer: ftw_act and Mode_o load at that edge; state stays IDLE.
- RUN transfer: Ftw_i/Mode_i go to the shadow regs; next state PEND.
- Accumulation: in RUN/PEND with En_i=1, acc <= (acc + ftw_act) mod 2^ACC_W each edge.
  - Address_o is driven directly from the acc register, so the new value is visible one cycle after the edge.
- Carry: carry = ((acc + ftw_act) >= 2^ACC_W).
  - Wrap_o is registered and equals carry, as a 1-cycle pulse.
- PEND apply at carry edge:
  - acc takes the sum computed with the OLD ftw_act.
  - ftw_act <= shadow FTW; Mode_o <= shadow mode; next state RUN.
  - Cfg_ready_o returns to 1 in the following cycle.
- PEND with ftw_act=0: the shadow config is applied at the next edge, because a zero FTW never produces a carry.
- Enable transitions:
  - IDLE with En_i=1: go to RUN; first accumulation at the following edge.
  - RUN/PEND with En_i=0: go to IDLE; acc holds its value.
  - PEND with En_i=0: the pending config is also applied at that edge.
- Valid_o: registered, equals 1 in the cycle after an edge with state RUN/PEND and En_i=1.
- Sync_clr_i=1, in any state:
  - acc <= 0 and Wrap_o <= 0.
  - Any pending config is applied and the state leaves PEND (to RUN if En_i=1, else IDLE).
  - Clear has priority over accumulation and over a simultaneous carry.
- Simultaneous transfer and carry in RUN: the transfer goes to the shadow regs and the carry does not apply it; it applies on the next carry.
- Reset mid-operation (including in PEND): all state is lost and the shadow contents are discarded.
- Arithmetic is unsigned and modulo 2^ACC_W. No saturation.

Decomposition:
- Package dds_pkg: ACC_W, ADDR_W and MODE_W defaults, plus the state encoding localparams IDLE=2'd0, RUN=2'd1, PEND=2'd2.
- Sub-module dds_acc_core (acc register, adder, carry detect, clear) is natural.
- The FSM, shadow regs and handshake stay in dds_phase_gen.

Test Plan:
1. Reset values: assert rst_n=0 mid-run -> all outputs at reset values asynchronously, with no clk edge required.
2. Linear sweep: IDLE transfer Ftw=0x0020_0000, Mode=0, then En_i=1 -> Address_o=0,1,2,... one step per cycle; 0x7FF to 0x000 after 2048 steps, with Wrap_o high exactly that one cycle.
3. Phase-continuous change, from Ftw=0x0020_0000 at Address_o=100: RUN transfer Ftw=0x0040_0000, Mode=4 -> Cfg_ready_o=0.
   - Step stays +1 and Mode_o stays 0 until the wrap.
   - After the wrap, step +2 and Mode_o=4.
   - Cfg_ready_o=1 the cycle after.
4. Ftw=0x8000_0000 -> Address_o alternates 0x000/0x400 and Wrap_o pulses every 2nd cycle.
5. Boundaries:
   - Ftw=0 in PEND -> the new config applies at the next edge.
   - Cfg_valid_i held high while Cfg_ready_o=0 -> exactly one transfer.
   - En_i dropped in PEND -> config applied, acc frozen.
6. Sync_clr_i=1 on the same edge as a carry -> Address_o=0, Wrap_o=0, pending config applied.
